dmi_req_arb: RTL and testbench

// Two-requester arbiter and sequencer for the single DMI register port of the debug module.

---
 rtl/dmi_pkg.sv | 15 +
 rtl/dmi_rr_arb2.sv | 17 +
 rtl/dmi_req_arb.sv | 111 +++++++++++
 tb/tb_dmi_req_arb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmi_pkg.sv
// rtl/dmi_pkg.sv - shared DMI sequencer state and status encodings
package dmi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } dmi_state_e;

   localparam logic [1:0] DMI_OK      = 2'b00;
   localparam logic [1:0] DMI_FAILED  = 2'b10;
   localparam logic [1:0] DMI_ABORTED = 2'b11;

endpackage

// File: rtl/dmi_rr_arb2.sv
// rtl/dmi_rr_arb2.sv - two-way round-robin pick, pointer owned by the caller
module dmi_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] grant
);

   // A lone requester always wins; the pointer only breaks a tie.
   always_comb begin
      grant = valid;
      if (valid == 2'b11) begin
         grant      = 2'b00;
         grant[ptr] = 1'b1;
      end
   end

endmodule

// File: rtl/dmi_req_arb.sv
// rtl/dmi_req_arb.sv - two-requester arbiter/sequencer for the single DMI port
module dmi_req_arb
   import dmi_pkg::*;
#(
   parameter int ADDR_W  = 7,
   parameter int TMO_CYC = 255,
   parameter int TMO_W   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_write,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0][31:0]       req_wdata,
   output logic [1:0]             rsp_valid,
   output logic [31:0]            rsp_rdata,
   output logic [1:0]             rsp_status,
   output logic                   dmi_en,
   output logic                   dmi_wr_en,
   output logic [ADDR_W-1:0]      dmi_addr,
   output logic [31:0]            dmi_wdata,
   input  logic [31:0]            dmi_rdata,
   input  logic                   dmi_rsp,
   input  logic                   dmi_hard_reset,
   output logic                   busy
);

   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

   dmi_state_e       state;
   logic             ptr;
   logic             owner;
   logic [TMO_W-1:0] timer;
   logic [TMO_W-1:0] timer_inc;
   logic [1:0]       grant;
   logic [1:0]       owner_onehot;

   dmi_rr_arb2 u_pick (
      .valid (req_valid),
      .ptr   (ptr),
      .grant (grant)
   );

   assign req_ready    = (state == IDLE) ? grant : 2'b00;
   assign busy         = (state != IDLE);
   assign timer_inc    = timer + TMO_W'(1);
   assign owner_onehot = owner ? 2'b10 : 2'b01;

   // Abort beats a same-cycle response; a response beats the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         owner      <= 1'b0;
         timer      <= '0;
         rsp_valid  <= 2'b00;
         rsp_rdata  <= '0;
         rsp_status <= DMI_OK;
         dmi_en     <= 1'b0;
         dmi_wr_en  <= 1'b0;
         dmi_addr   <= '0;
         dmi_wdata  <= '0;
      end else begin
         dmi_en    <= 1'b0;
         dmi_wr_en <= 1'b0;
         rsp_valid <= 2'b00;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  owner     <= grant[1];
                  ptr       <= ~grant[1];
                  dmi_addr  <= req_addr[grant[1]];
                  dmi_wdata <= req_wdata[grant[1]];
                  dmi_en    <= 1'b1;
                  dmi_wr_en <= req_write[grant[1]];
                  state     <= ISSUE;
               end
            end
            ISSUE, WAIT: begin
               timer <= (state == ISSUE) ? '0 : timer_inc;
               if (dmi_hard_reset) begin
                  rsp_valid  <= owner_onehot;
                  rsp_rdata  <= '0;
                  rsp_status <= DMI_ABORTED;
                  state      <= RESP;
               end else if (dmi_rsp) begin
                  rsp_valid  <= owner_onehot;
                  rsp_rdata  <= dmi_rdata;
                  rsp_status <= DMI_OK;
                  state      <= RESP;
               end else if (state == WAIT && timer_inc == TMO_LIM) begin
                  rsp_valid  <= owner_onehot;
                  rsp_rdata  <= '0;
                  rsp_status <= DMI_FAILED;
                  state      <= RESP;
               end else begin
                  state <= WAIT;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmi_req_arb.sv
// tb/tb_dmi_req_arb.sv - randomized and directed checks of dmi_req_arb against a transaction-level model
module tb_dmi_req_arb;

   localparam int AW  = 7;
   localparam int TMO = 4;
   localparam int NONE = -1;

   logic                clk;
   logic                rst;
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [1:0]          req_write;
   logic [1:0][AW-1:0]  req_addr;
   logic [1:0][31:0]    req_wdata;
   logic [1:0]          rsp_valid;
   logic [31:0]         rsp_rdata;
   logic [1:0]          rsp_status;
   logic                dmi_en;
   logic                dmi_wr_en;
   logic [AW-1:0]       dmi_addr;
   logic [31:0]         dmi_wdata;
   logic [31:0]         dmi_rdata;
   logic                dmi_rsp;
   logic                dmi_hard_reset;
   logic                busy;

   int vectors     = 0;
   int miscompares = 0;
   int ptr_m       = 0;

   dmi_req_arb #(.ADDR_W(AW), .TMO_CYC(TMO), .TMO_W(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_status     (rsp_status),
      .dmi_en         (dmi_en),
      .dmi_wr_en      (dmi_wr_en),
      .dmi_addr       (dmi_addr),
      .dmi_wdata      (dmi_wdata),
      .dmi_rdata      (dmi_rdata),
      .dmi_rsp        (dmi_rsp),
      .dmi_hard_reset (dmi_hard_reset),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One access: model picks the owner from (ptr, valid) and derives outcome and
   // response time from when the target answers (d) or an abort arrives (k),
   // both counted in cycles after the dmi_en cycle.
   task automatic access(input logic [1:0] rv, input logic [1:0] wr,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input int d, input int k, input logic [31:0] data);
      int          owner;
      int          t_end;
      logic [1:0]  st;
      logic [31:0] rd;
      logic [1:0]  onehot;
      logic [AW-1:0] ea;
      logic [31:0] ew;
      if (rv == 2'b11) owner = ptr_m;
      else owner = rv[1] ? 1 : 0;
      ptr_m  = 1 - owner;
      onehot = (owner == 1) ? 2'b10 : 2'b01;
      ea     = (owner == 1) ? a1 : a0;
      ew     = (owner == 1) ? w1 : w0;
      if (k >= 0 && k <= TMO && (d < 0 || d > TMO || k <= d)) begin
         st = 2'b11; rd = '0; t_end = k + 1;
      end else if (d >= 0 && d <= TMO) begin
         st = 2'b00; rd = data; t_end = d + 1;
      end else begin
         st = 2'b10; rd = '0; t_end = TMO + 1;
      end

      req_valid      = rv;
      req_write      = wr;
      req_addr[0]    = a0;
      req_addr[1]    = a1;
      req_wdata[0]   = w0;
      req_wdata[1]   = w1;
      dmi_rsp        = 1'($urandom);
      dmi_hard_reset = 1'($urandom);
      dmi_rdata      = $urandom;
      #1;
      check("req_ready", req_ready, onehot);
      check("busy_idle", busy, 1'b0);

      @(negedge clk);
      req_valid      = 2'b00;
      dmi_rsp        = 1'b0;
      dmi_hard_reset = 1'b0;
      dmi_rdata      = $urandom;
      check("dmi_en", dmi_en, 1'b1);
      check("dmi_wr_en", dmi_wr_en, wr[owner]);
      check("dmi_addr", dmi_addr, ea);
      check("dmi_wdata", dmi_wdata, ew);
      check("rsp_early", rsp_valid, 2'b00);
      if (d == 0) begin dmi_rsp = 1'b1; dmi_rdata = data; end
      if (k == 0) dmi_hard_reset = 1'b1;

      for (int c = 1; c <= t_end; c++) begin
         @(negedge clk);
         dmi_rsp        = 1'b0;
         dmi_hard_reset = 1'b0;
         dmi_rdata      = $urandom;
         if (c == t_end) begin
            check("rsp_valid", rsp_valid, onehot);
            check("rsp_rdata", rsp_rdata, rd);
            check("rsp_status", rsp_status, st);
            dmi_rsp        = 1'b1;
            dmi_hard_reset = 1'($urandom);
         end else begin
            check("rsp_wait", rsp_valid, 2'b00);
            check("dmi_en_once", dmi_en, 1'b0);
            if (c == d) begin dmi_rsp = 1'b1; dmi_rdata = data; end
            if (c == k) dmi_hard_reset = 1'b1;
         end
      end

      @(negedge clk);
      dmi_rsp        = 1'b0;
      dmi_hard_reset = 1'b0;
      check("rsp_pulse", rsp_valid, 2'b00);
      check("busy_done", busy, 1'b0);
      check("rdata_hold", rsp_rdata, rd);
      check("status_hold", rsp_status, st);
   endtask

   initial begin
      rst            = 1'b1;
      req_valid      = '0;
      req_write      = '0;
      req_addr       = '0;
      req_wdata      = '0;
      dmi_rdata      = '0;
      dmi_rsp        = 1'b0;
      dmi_hard_reset = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_dmi_en", dmi_en, 1'b0);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_rdata", rsp_rdata, 32'h0);
      check("rst_ready", req_ready, 2'b00);
      rst = 1'b0;
      @(negedge clk);

      // Both requesters held valid: grants alternate starting with requester 0.
      for (int i = 0; i < 4; i++)
         access(2'b11, 2'b00, 7'h01, 7'h02, 32'h0, 32'h0, 2, NONE, 32'hA0 + i);

      access(2'b01, 2'b00, 7'h11, 7'h22, 32'h0, 32'h0, 2, NONE, 32'hDEADBEEF);
      access(2'b10, 2'b10, 7'h05, 7'h10, 32'h9, 32'h1, 1, NONE, 32'h5);
      access(2'b01, 2'b00, 7'h33, 7'h00, 32'h0, 32'h0, NONE, NONE, 32'h77);
      access(2'b10, 2'b00, 7'h00, 7'h34, 32'h0, 32'h0, TMO, NONE, 32'h12345678);
      access(2'b01, 2'b01, 7'h40, 7'h00, 32'hCAFE, 32'h0, NONE, 2, 32'h0);
      access(2'b01, 2'b00, 7'h41, 7'h00, 32'h0, 32'h0, 0, NONE, 32'h600DF00D);
      access(2'b11, 2'b00, 7'h42, 7'h43, 32'h0, 32'h0, NONE, TMO, 32'h0);

      for (int i = 0; i < 40; i++) begin
         int d;
         int k;
         d = int'($urandom_range(0, TMO + 2));
         k = NONE;
         if ($urandom_range(0, 3) == 0) k = int'($urandom_range(0, TMO + 1));
         access(2'($urandom_range(1, 3)), 2'($urandom), 7'($urandom), 7'($urandom),
                $urandom, $urandom, d, k, $urandom);
      end

      // Reset in the middle of WAIT: outputs clear at once and the pointer returns to 0.
      access(2'b01, 2'b00, 7'h01, 7'h00, 32'h0, 32'h0, 0, NONE, 32'h1);
      req_valid = 2'b10;
      req_write = 2'b10;
      req_addr[1] = 7'h55;
      req_wdata[1] = 32'hFEED;
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      check("pre_rst_busy", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_dmi_addr", dmi_addr, 7'h0);
      check("arst_dmi_wdata", dmi_wdata, 32'h0);
      check("arst_rsp_valid", rsp_valid, 2'b00);
      check("arst_dmi_en", dmi_en, 1'b0);
      @(negedge clk);
      rst   = 1'b0;
      ptr_m = 0;
      @(negedge clk);
      access(2'b11, 2'b01, 7'h11, 7'h12, 32'h3, 32'h4, 1, NONE, 32'h99);
      access(2'b11, 2'b00, 7'h13, 7'h14, 32'h5, 32'h6, 3, NONE, 32'h98);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
